// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Central hazard controller for the 5-stage RISC-V pipeline. It detects
//   load-use hazards from the ID/EX fields, and it uses a small FSM to
//   sequence memory-busy stalls. A branch that resolves while memory is busy
//   has its IF/ID flush deferred until the stall ends. A sticky timeout flag
//   sets when memory stays busy for too long.
//
//   Optional build macro: HAZARD_PERF_CNT_EN
//     When it is defined, the saturating counters stall_cnt and flush_cnt are
//     added.
//
// Ports
//   clk, rst            core clock (rising edge); async active-high reset
//   rs1/rs2_from_id     source registers of the ID instruction
//   rs1/rs2_used_id     ID instruction actually reads rs1/rs2
//   rd_to_ex            destination register of the EX instruction
//   read_mem_to_ex      EX instruction is a load
//   write_reg_to_ex     EX instruction writes rd
//   branch_taken_ex     EX resolved a taken branch/jump (1-cycle pulse)
//   mem_busy            data memory not ready; MEM must hold
//   pc_stall            hold PC
//   if_id_stall         hold IF/ID and ID/EX
//   id_stall_req        bubble: zero the ID/EX control fields
//   if_id_flush         replace IF/ID with a NOP
//   ex_mem_stall        hold EX/MEM
//   mem_timeout         sticky: memory was busy for MAX_WAIT cycles
//   stall_cnt/flush_cnt (HAZARD_PERF_CNT_EN only) saturating event counters
//   state_dbg           current FSM state (RUN=0, MEM_WAIT=1, FLUSH=2)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 64,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_from_id,
    input  logic [4:0]       rs2_from_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_to_ex,
    input  logic             read_mem_to_ex,
    input  logic             write_reg_to_ex,
    input  logic             branch_taken_ex,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_stall_req,
    output logic             if_id_flush,
    output logic             ex_mem_stall,
    output logic             mem_timeout,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic             timeout_q, timeout_d;

    logic load_use;
    logic pc_stall_c, if_id_stall_c, id_stall_req_c, if_id_flush_c, ex_mem_stall_c;

    // A load into x0 never creates a dependency.
    always_comb begin
        load_use = read_mem_to_ex & write_reg_to_ex & (rd_to_ex != 5'd0) &
                   ((rs1_used_id & (rs1_from_id == rd_to_ex)) |
                    (rs2_used_id & (rs2_from_id == rd_to_ex)));
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        flush_pend_d   = flush_pend_q;
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        id_stall_req_c = 1'b0;
        if_id_flush_c  = 1'b0;
        ex_mem_stall_c = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    ex_mem_stall_c = 1'b1;
                    state_d        = MEM_WAIT;
                    cnt_d          = ONE_C;
                    if (branch_taken_ex) begin
                        flush_pend_d = 1'b1;
                    end
                end else if (branch_taken_ex) begin
                    // The branch squashes the dependent instruction, so a
                    // concurrent load-use needs no stall.
                    if_id_flush_c  = 1'b1;
                    id_stall_req_c = 1'b1;
                end else if (load_use) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    id_stall_req_c = 1'b1;
                end
            end
            MEM_WAIT: begin
                // EX is frozen here, so load_use and branch_taken_ex are stale.
                if (mem_busy) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    ex_mem_stall_c = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = flush_pend_q ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                if_id_flush_c  = 1'b1;
                id_stall_req_c = 1'b1;
                flush_pend_d   = 1'b0;
                state_d        = RUN;
                if (mem_busy) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    ex_mem_stall_c = 1'b1;
                    state_d        = MEM_WAIT;
                    cnt_d          = ONE_C;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        timeout_d = timeout_q | (mem_busy & (cnt_d == MAX_WAIT_C));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            timeout_q    <= timeout_d;
        end
    end

    // The outputs are combinational from the inputs. They are gated by rst so
    // that a reset during a stall releases the pipeline at once, even while
    // mem_busy is still high.
    always_comb begin
        pc_stall     = pc_stall_c     & ~rst;
        if_id_stall  = if_id_stall_c  & ~rst;
        id_stall_req = id_stall_req_c & ~rst;
        if_id_flush  = if_id_flush_c  & ~rst;
        ex_mem_stall = ex_mem_stall_c & ~rst;
        mem_timeout  = timeout_q;
        state_dbg    = state_q;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_stall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + ONE_C;
            end
            if (if_id_flush && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + ONE_C;
            end
        end
    end

    always_comb begin
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_from_id, rs2_from_id, rd_to_ex;
    logic       rs1_used_id, rs2_used_id;
    logic       read_mem_to_ex, write_reg_to_ex, branch_taken_ex, mem_busy;
    logic       pc_stall, if_id_stall, id_stall_req, if_id_flush, ex_mem_stall, mem_timeout;
    logic [1:0] state_dbg;
`ifdef HAZARD_PERF_CNT_EN
    logic [7:0] stall_cnt, flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.MAX_WAIT(4), .CNT_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .rs1_from_id     (rs1_from_id),
        .rs2_from_id     (rs2_from_id),
        .rs1_used_id     (rs1_used_id),
        .rs2_used_id     (rs2_used_id),
        .rd_to_ex        (rd_to_ex),
        .read_mem_to_ex  (read_mem_to_ex),
        .write_reg_to_ex (write_reg_to_ex),
        .branch_taken_ex (branch_taken_ex),
        .mem_busy        (mem_busy),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .id_stall_req    (id_stall_req),
        .if_id_flush     (if_id_flush),
        .ex_mem_stall    (ex_mem_stall),
        .mem_timeout     (mem_timeout),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
`endif
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    // Move to 1 ns after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rs1_from_id = 5'd0; rs2_from_id = 5'd0; rd_to_ex = 5'd0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0;
        read_mem_to_ex = 1'b0; write_reg_to_ex = 1'b0;
        branch_taken_ex = 1'b0; mem_busy = 1'b0;
    endtask

    // e = {pc_stall, if_id_stall, id_stall_req, if_id_flush, ex_mem_stall, mem_timeout}
    task automatic look(input string tag, input logic [5:0] e, input logic [1:0] es);
        logic [5:0] obs;
        #2;
        obs = {pc_stall, if_id_stall, id_stall_req, if_id_flush, ex_mem_stall, mem_timeout};
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s outputs=%b expected=%b", tag, obs, e);
        end
        checks++;
        assert (state_dbg === es) else begin
            errors++;
            $error("FAIL %s_state state_dbg=%0d expected=%0d", tag, state_dbg, es);
        end
    endtask

    initial begin
        clr();
        rst = 1'b1;
        look("reset", 6'b000000, 2'd0);
        #10;
        rst = 1'b0;

        // Load x5 in EX; ID reads x5 via rs1, so there is one bubble cycle.
        nxt(); rd_to_ex = 5'd5; read_mem_to_ex = 1'b1; write_reg_to_ex = 1'b1;
        rs1_from_id = 5'd5; rs1_used_id = 1'b1; rs2_from_id = 5'd1; rs2_used_id = 1'b1;
        look("lu_rs1", 6'b111000, 2'd0);
        nxt(); read_mem_to_ex = 1'b0;   // the bubble has reached EX
        look("lu_after", 6'b000000, 2'd0);
        // Hazard through rs2.
        nxt(); read_mem_to_ex = 1'b1; rs1_from_id = 5'd3; rs2_from_id = 5'd5;
        look("lu_rs2", 6'b111000, 2'd0);
        // rs2 matches but is not used.
        nxt(); rs2_used_id = 1'b0;
        look("lu_unused", 6'b000000, 2'd0);
        // Not a register write.
        nxt(); rs2_used_id = 1'b1; write_reg_to_ex = 1'b0;
        look("lu_nowr", 6'b000000, 2'd0);
        // Load x0 in EX, ID reads x0.
        nxt(); clr(); rd_to_ex = 5'd0; read_mem_to_ex = 1'b1; write_reg_to_ex = 1'b1;
        rs1_from_id = 5'd0; rs1_used_id = 1'b1;
        look("lu_x0", 6'b000000, 2'd0);

        // mem_busy for 3 cycles. A load-use in MEM_WAIT must be ignored.
        nxt(); clr(); mem_busy = 1'b1;
        look("busy_c1", 6'b110010, 2'd0);
        nxt(); rd_to_ex = 5'd7; read_mem_to_ex = 1'b1; write_reg_to_ex = 1'b1;
        rs1_from_id = 5'd7; rs1_used_id = 1'b1;
        look("busy_c2", 6'b110010, 2'd1);
        nxt();
        look("busy_c3", 6'b110010, 2'd1);
        nxt(); clr();
        look("busy_end", 6'b000000, 2'd1);
        nxt();
        look("busy_run", 6'b000000, 2'd0);

        // A branch in RUN flushes; a branch beats a concurrent load-use.
        nxt(); branch_taken_ex = 1'b1;
        look("br", 6'b001100, 2'd0);
        nxt(); rd_to_ex = 5'd9; read_mem_to_ex = 1'b1; write_reg_to_ex = 1'b1;
        rs2_from_id = 5'd9; rs2_used_id = 1'b1;
        look("br_lu", 6'b001100, 2'd0);

        // The branch rises together with mem_busy, so its flush is deferred.
        nxt(); clr(); branch_taken_ex = 1'b1; mem_busy = 1'b1;
        look("dbr_c1", 6'b110010, 2'd0);
        nxt(); branch_taken_ex = 1'b0;
        look("dbr_c2", 6'b110010, 2'd1);
        nxt(); mem_busy = 1'b0;
        look("dbr_end", 6'b000000, 2'd1);
        nxt();
        look("dbr_flush", 6'b001100, 2'd2);
        nxt();
        look("dbr_run", 6'b000000, 2'd0);

        // mem_busy reasserts during FLUSH, which takes priority.
        nxt(); branch_taken_ex = 1'b1; mem_busy = 1'b1;
        look("fb_c1", 6'b110010, 2'd0);
        nxt(); branch_taken_ex = 1'b0;
        look("fb_c2", 6'b110010, 2'd1);
        nxt(); mem_busy = 1'b0;
        look("fb_end", 6'b000000, 2'd1);
        nxt(); mem_busy = 1'b1;
        look("fb_flush_busy", 6'b111110, 2'd2);
        nxt(); mem_busy = 1'b0;
        look("fb_wait", 6'b000000, 2'd1);
        nxt();
        look("fb_run_nopend", 6'b000000, 2'd0);

        // Timeout: MAX_WAIT=4 and busy is held for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            nxt(); mem_busy = 1'b1;
            look("to_loop", {5'b11001, logic'(i >= 4)}, (i == 0) ? 2'd0 : 2'd1);
        end
        nxt(); mem_busy = 1'b0;
        look("to_end", 6'b000001, 2'd1);
        nxt();
        look("to_sticky", 6'b000001, 2'd0);
        #1; rst = 1'b1;
        look("to_rst", 6'b000000, 2'd0);
        #2; rst = 1'b0;
        nxt();
        look("to_cleared", 6'b000000, 2'd0);

        // Reset asserted in the middle of MEM_WAIT while busy stays high.
        nxt(); mem_busy = 1'b1;
        look("rm_c1", 6'b110010, 2'd0);
        nxt();
        look("rm_c2", 6'b110010, 2'd1);
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        assert (stall_cnt === 8'd1) else begin
            errors++;
            $error("FAIL rm_stall_cnt stall_cnt=%0d expected=1", stall_cnt);
        end
`endif
        #1; rst = 1'b1;
        look("rm_async", 6'b000000, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        assert (stall_cnt === 8'd0) else begin
            errors++;
            $error("FAIL rm_stall_cnt0 stall_cnt=%0d expected=0", stall_cnt);
        end
`endif
        nxt(); mem_busy = 1'b0;
        look("rm_hold", 6'b000000, 2'd0);
        #1; rst = 1'b0;
        nxt();
        look("rm_idle", 6'b000000, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
